// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction/PC geometry used by fetch and
// the instruction-memory loader, plus the loader's FSM state encoding.
package processor_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam logic [15:0] PC_INCR     = 16'd2;

  localparam logic [15:0] LOADER_BASE_ADDR_DEFAULT = 16'h0000;
  localparam int unsigned LOADER_MAX_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_LEN_HI  = 3'd1,
    LD_LEN_LO  = 3'd2,
    LD_DATA_HI = 3'd3,
    LD_DATA_LO = 3'd4,
    LD_CHECK   = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERR     = 3'd7
  } loader_state_e;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// slave = the loader, master = stream source / memory side.
interface inst_mem_loader_if;
  import processor_pkg::*;

  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   byte_ready;
  logic                   im_we;
  logic [15:0]            im_addr;
  logic [INSTR_WIDTH-1:0] im_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/inst_mem_loader_xor_checksum.sv
// Running 8-bit XOR accumulator; clear has priority over enable.
module xor_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= 8'h00;
    end else if (clr) begin
      sum <= 8'h00;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory as 16-bit words and holds the CPU until a load completes cleanly.
module inst_mem_loader
  import processor_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = LOADER_BASE_ADDR_DEFAULT,
  parameter int unsigned MAX_WORDS = LOADER_MAX_WORDS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  inst_mem_loader_if.slave        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    cpu_hold,
  output logic [15:0]             word_count
);

  loader_state_e state, state_nx;

  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  data_hi;
  logic [7:0]  chk_sum;
  logic        xfer;
  logic        start_load;
  logic [15:0] len_full;

  assign busy       = (state == LD_LEN_HI)  || (state == LD_LEN_LO) ||
                      (state == LD_DATA_HI) || (state == LD_DATA_LO) ||
                      (state == LD_CHECK);
  assign bus.byte_ready = busy;
  assign err        = (state == LD_ERR);
  assign cpu_hold   = (state != LD_DONE);

  assign xfer       = bus.byte_valid && busy;
  assign start_load = start && !busy;
  assign len_full   = {len_hi, bus.byte_data};

  xor_checksum u_chk (
    .clk (clk),
    .rst (rst),
    .clr (start_load),
    .en  (xfer && ((state == LD_DATA_HI) || (state == LD_DATA_LO))),
    .din (bus.byte_data),
    .sum (chk_sum)
  );

  always_comb begin
    // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
    state_nx = state;
    unique case (state)
      LD_IDLE, LD_DONE, LD_ERR: if (start) state_nx = LD_LEN_HI;
      LD_LEN_HI:  if (xfer) state_nx = LD_LEN_LO;
      LD_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)                  state_nx = LD_CHECK;
          else if (32'(len_full) > MAX_WORDS)     state_nx = LD_ERR;
          else                                    state_nx = LD_DATA_HI;
        end
      end
      LD_DATA_HI: if (xfer) state_nx = LD_DATA_LO;
      LD_DATA_LO: begin
        if (xfer) state_nx = (word_count + 16'd1 == len) ? LD_CHECK : LD_DATA_HI;
      end
      LD_CHECK: begin
        if (xfer) state_nx = (bus.byte_data == chk_sum) ? LD_DONE : LD_ERR;
      end
      default: state_nx = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LD_IDLE;
      len_hi       <= 8'h00;
      len          <= 16'h0000;
      data_hi      <= 8'h00;
      word_count   <= 16'h0000;
      done         <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= BASE_ADDR;
      bus.im_wdata <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state     <= state_nx;
      done      <= (state == LD_CHECK) && xfer && (bus.byte_data == chk_sum);
      bus.im_we <= 1'b0;

      // Address steps once the write cycle is over, so it is stable during im_we.
      if (bus.im_we) bus.im_addr <= bus.im_addr + PC_INCR;

      unique case (state)
        LD_LEN_HI:  if (xfer) len_hi <= bus.byte_data;
        LD_LEN_LO:  if (xfer) len    <= len_full;
        LD_DATA_HI: if (xfer) data_hi <= bus.byte_data;
        LD_DATA_LO: begin
          if (xfer) begin
            bus.im_we    <= 1'b1;
            bus.im_wdata <= {data_hi, bus.byte_data};
            word_count   <= word_count + 16'd1;
          end
        end
        default: ;
      endcase

      if (start_load) begin
        word_count  <= 16'h0000;
        bus.im_addr <= BASE_ADDR;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader against a stream-level model.
module tb_inst_mem_loader;

  localparam logic [15:0] BASE  = 16'h0000;
  localparam int          MAX_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err, cpu_hold;
  logic [15:0] word_count;

  inst_mem_loader_if bus ();

  inst_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         got_wr[$];
  int          done_pulses;
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic [15:0] stim[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.im_we) got_wr.push_back('{bus.im_addr, bus.im_wdata, cyc});
    if (done) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] stim_xor();
    logic [7:0] x = 8'h00;
    foreach (stim[i]) x = x ^ stim[i][15:8] ^ stim[i][7:0];
    return x;
  endfunction

  // Present one byte, optionally after random idle gaps; returns #1 after its transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    budget = 0;
    while (!bus.byte_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.byte_ready) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full load of stim[] with the given length field and checksum byte.
  task automatic run_stream(input string tag, input logic [15:0] len,
                            input logic [7:0] chk, input bit gaps);
    bit ok;
    bit oversize;
    oversize = (int'(len) > MAX_W);
    ok = !oversize && (chk == stim_xor());
    got_wr.delete();
    done_pulses = 0;

    pulse_start();
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_err"}, err, 0);
    check({tag, "_start_hold"}, cpu_hold, 1);
    check({tag, "_start_wc"}, word_count, 0);

    send_byte(len[15:8], gaps);
    send_byte(len[7:0], gaps);

    if (oversize) begin
      check({tag, "_ovr_err"}, err, 1);
      check({tag, "_ovr_ready"}, bus.byte_ready, 0);
      check({tag, "_ovr_busy"}, busy, 0);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_ovr_writes"}, got_wr.size(), 0);
      check({tag, "_ovr_done"}, done_pulses, 0);
      check({tag, "_ovr_hold"}, cpu_hold, 1);
      check({tag, "_ovr_wc"}, word_count, 0);
    end else begin
      foreach (stim[i]) begin
        send_byte(stim[i][15:8], gaps);
        send_byte(stim[i][7:0], gaps);
      end
      send_byte(chk, gaps);
      check({tag, "_done_now"}, done, ok);
      check({tag, "_hold_now"}, cpu_hold, !ok);
      check({tag, "_err_now"}, err, !ok);
      check({tag, "_busy_end"}, busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_pulses"}, done_pulses, ok ? 1 : 0);
      check({tag, "_hold_late"}, cpu_hold, !ok);
      check({tag, "_err_late"}, err, !ok);
      check({tag, "_wc"}, word_count, len);
      check({tag, "_nwrites"}, got_wr.size(), stim.size());
      for (int i = 0; i < got_wr.size() && i < stim.size(); i++) begin
        check({tag, "_addr"}, got_wr[i].addr, BASE + 16'(2 * i));
        check({tag, "_data"}, got_wr[i].data, stim[i]);
        if (!gaps && i > 0) check({tag, "_spacing"}, got_wr[i].cyc - got_wr[i-1].cyc, 2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    done_pulses = 0;
    rst   = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    #12;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", bus.byte_ready, 0);
    check("rst_we", bus.im_we, 0);
    check("rst_addr", bus.im_addr, BASE);
    check("rst_wdata", bus.im_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wc", word_count, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_hold", cpu_hold, 1);
    check("idle_ready", bus.byte_ready, 0);
    check("idle_writes", got_wr.size(), 0);

    // Directed: 2-word load, good then bad checksum, then stalled load
    stim = '{16'h1234, 16'hABCD};
    run_stream("two_ok", 16'd2, 8'h40, 1'b0);
    run_stream("two_badchk", 16'd2, 8'h41, 1'b0);
    run_stream("two_stall", 16'd2, 8'h40, 1'b1);

    // Boundaries: empty load, exactly MAX_WORDS, one past MAX_WORDS
    stim.delete();
    run_stream("len0", 16'd0, 8'h00, 1'b0);
    stim = '{16'hDEAD, 16'hBEEF, 16'h0102, 16'hF00D};
    run_stream("len_max", 16'd4, stim_xor(), 1'b0);
    stim.delete();
    run_stream("len_over", 16'd5, 8'h00, 1'b0);
    run_stream("len_huge", 16'hFFFF, 8'h00, 1'b1);

    // Abort by reset after the first write
    stim = '{16'h1234, 16'hABCD};
    got_wr.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check("abort_we1", bus.im_we, 1);
    check("abort_addr1", bus.im_addr, BASE);
    check("abort_data1", bus.im_wdata, 16'h1234);
    send_byte(8'hAB, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hold", cpu_hold, 1);
    check("abort_ready", bus.byte_ready, 0);
    check("abort_we", bus.im_we, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hCD;
    repeat (4) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    check("abort_writes", got_wr.size(), 1);
    check("abort_hold2", cpu_hold, 1);
    check("abort_busy2", busy, 0);

    // Randomized loads: lengths around the limit, random stalls and corruptions
    for (int k = 0; k < 14; k++) begin
      int          len;
      logic [7:0]  chk;
      bit          gaps;
      len  = $urandom_range(0, MAX_W + 1);
      gaps = 1'($urandom_range(0, 1));
      stim.delete();
      if (len <= MAX_W) begin
        for (int j = 0; j < len; j++) stim.push_back(16'($urandom));
      end
      chk = stim_xor();
      if ($urandom_range(0, 2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_stream("rand", 16'(len), chk, gaps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writes a program image into instruction memory from a byte stream. It is the write side of the instruction-memory port that the fetch stage reads. The loader receives a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles 16-bit words. It issues one write per word at byte addresses BASE_ADDR, BASE_ADDR+2, … and holds the CPU (gating pcwrite) until a load completes cleanly.

## Interface
- BASE_ADDR, 16'h0000, byte address of first word written; must be even
- MAX_WORDS, 1024, largest accepted length field; larger values are an error
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when idle, done or errored
- byte_valid  in  1  stream byte present
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  16  write byte address
- im_wdata  out  16  write word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error; cleared by start or reset
- cpu_hold  out  1  high = CPU must not fetch/advance PC
- word_count  out  16  words written in current/last load

## Operation
- Stream format: LEN_HI, LEN_LO, then 2×LEN data bytes with each word high byte first, then one CHK byte. CHK is the XOR of all data bytes, excluding the length bytes.
- A byte transfers on a rising edge with byte_valid && byte_ready.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- IDLE/DONE/ERR -> LEN_HI on start. Entering LEN_HI clears err, word_count and the checksum, and sets im_addr to BASE_ADDR.
- LEN_HI -> LEN_LO on transfer.
- LEN_LO -> DATA_HI on transfer if 0 < LEN <= MAX_WORDS.
- LEN_LO -> CHECK if LEN == 0.
- LEN_LO -> ERR if LEN > MAX_WORDS.
- DATA_HI -> DATA_LO on transfer; the byte is latched as the high byte.
- DATA_LO -> DATA_HI on transfer, or -> CHECK if this was word LEN.
- CHECK -> DONE if the received byte equals the accumulated XOR, else -> ERR.
- byte_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
- busy = 1 in those same states.
- start while busy is ignored.
- Write: on each DATA_LO transfer, im_we pulses and word_count increments. im_addr advances by 2 after each write. Address arithmetic is 16-bit modulo; BASE_ADDR + 2×MAX_WORDS must not exceed 16'hFFFF.
- cpu_hold = 1 from reset, and in every state except DONE. It is 0 in DONE and stays 0 until the next start.
- ERR leaves cpu_hold = 1 and err = 1 until start. Memory contents already written are not rolled back.

## Timing
- Reset values: byte_ready 0, im_we 0, im_addr BASE_ADDR, im_wdata 0, busy 0, done 0, err 0, cpu_hold 1, word_count 0, FSM IDLE.
- im_we, im_addr and im_wdata are registered. They are valid in the cycle after the DATA_LO transfer edge, with im_we high for exactly one cycle. im_addr is stable for the whole im_we cycle.
- One byte per cycle is sustained, so back-to-back words give im_we every second cycle.
- done and the drop of cpu_hold occur in the cycle after the CHECK transfer edge.
- Stalls (byte_valid low) in any state hold all state; no timeout.
- Reset asserted mid-load aborts immediately: FSM IDLE, cpu_hold 1, no further writes.

## Structure
- Shared package processor_pkg holds:
  - the loader FSM state enum;
  - LOADER_BASE_ADDR_DEFAULT and LOADER_MAX_WORDS_DEFAULT;
  - the instruction width (16) and PC increment (2), shared with the fetch stage.
- One sub-module, xor_checksum: 8-bit accumulator with clear, enable and data-in, exposing the running value.

## Test plan
- Reset then idle: rst low → cpu_hold 1, byte_ready 0, im_we never asserts.
- Load 2 words, BASE 0, stream 00 02 12 34 AB CD 40. Required: writes (0x0000, 0x1234) then (0x0002, 0xABCD); done pulses once; cpu_hold falls to 0; word_count 2.
- Bad checksum: same stream with CHK 41 → both writes occur, err 1, cpu_hold stays 1, done never pulses. A subsequent start clears err.
- Length 0: stream 00 00 00 → no im_we, done pulses, cpu_hold 0.
- Oversize length with MAX_WORDS 4: stream 00 05 → ERR immediately after LEN_LO, byte_ready 0, no writes.
- Stall and abort:
  - Random byte_valid gaps during the 2-word load → identical writes and checksum result.
  - rst pulsed after the first write → FSM IDLE, cpu_hold 1, no second write.
